// File: rtl/elevator_controller.sv
// Sweep-order floor scheduler for a 4-bit up/down floor counter.
// Latches calls, steers Up/S so the car stops at each pending floor.
module elevator_controller #(
  parameter int NUM_FLOORS  = 10,
  parameter int DOOR_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic [3:0]            floor,
  output logic                  Up,
  output logic                  S,
  output logic                  door_open,
  output logic                  moving,
  output logic [NUM_FLOORS-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic [7:0] DOOR_LOAD = 8'(DOOR_CYCLES - 1);

  state_t                r_state;
  logic                  r_dir;
  logic [NUM_FLOORS-1:0] r_pend;
  logic [7:0]            r_timer;

  logic                  w_valid;
  logic                  w_above;
  logic                  w_below;
  logic                  w_here;
  logic                  w_req_here;
  logic [NUM_FLOORS-1:0] w_clr;
  logic                  w_ahead;
  logic                  w_behind;
  logic                  w_top;
  logic                  w_bot;
  logic                  w_limit;
  logic                  w_hold_move;

  assign w_valid = (int'(floor) < NUM_FLOORS);
  assign w_top   = (int'(floor) == NUM_FLOORS - 1);
  assign w_bot   = (floor == 4'd0);

  // An out-of-range floor counts as above every served floor.
  always_comb begin
    w_above    = 1'b0;
    w_below    = 1'b0;
    w_here     = 1'b0;
    w_req_here = 1'b0;
    w_clr      = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (!w_valid) begin
        w_below = w_below | r_pend[i];
      end else if (i > int'(floor)) begin
        w_above = w_above | r_pend[i];
      end else if (i < int'(floor)) begin
        w_below = w_below | r_pend[i];
      end else begin
        w_here     = r_pend[i];
        w_req_here = req[i];
        w_clr[i]   = (r_state == DOOR);
      end
    end
  end

  assign w_ahead  = r_dir ? w_above : w_below;
  assign w_behind = r_dir ? w_below : w_above;
  assign w_limit  = (r_dir & w_top) | (~r_dir & w_bot);

  assign w_hold_move = w_here | ~w_ahead | ~w_valid | w_limit;

  assign S         = (r_state != MOVE) | w_hold_move;
  assign moving    = (r_state == MOVE) & ~w_hold_move;
  assign Up        = r_dir;
  assign door_open = (r_state == DOOR);
  assign pending   = r_pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend | req) & ~w_clr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_dir   <= 1'b1;
      r_timer <= 8'd0;
    end else if (!w_valid) begin
      r_state <= IDLE;
      if (|r_pend) r_dir <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_here) begin
            r_state <= DOOR;
            r_timer <= DOOR_LOAD;
          end else if (w_ahead) begin
            r_state <= MOVE;
          end else if (w_behind) begin
            r_state <= MOVE;
            r_dir   <= ~r_dir;
          end
        end
        MOVE: begin
          if (w_here) begin
            r_state <= DOOR;
            r_timer <= DOOR_LOAD;
          end else if (!w_ahead || w_limit) begin
            r_state <= IDLE;
          end
        end
        DOOR: begin
          if (w_req_here) begin
            r_timer <= DOOR_LOAD;
          end else if (r_timer == 8'd0) begin
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller with a behavioural floor counter.
// Each step advances one clock and checks outputs 1 time unit after the edge.
module tb_elevator_controller;

  localparam int NF = 10;

  logic          clk;
  logic          reset;
  logic [NF-1:0] req;
  logic [3:0]    floor;
  logic          Up;
  logic          S;
  logic          door_open;
  logic          moving;
  logic [NF-1:0] pending;

  int n_vec;
  int n_err;

  elevator_controller #(.NUM_FLOORS(NF), .DOOR_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .floor     (floor),
    .Up        (Up),
    .S         (S),
    .door_open (door_open),
    .moving    (moving),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset)  floor <= 4'd0;
    else if (!S) floor <= Up ? floor + 4'd1 : floor - 4'd1;
  end

  // Direction must stay put across any edge where the counter stepped.
  logic p_s, p_up;
  always @(posedge clk) begin
    p_s  = S;
    p_up = Up;
  end
  always @(negedge clk) begin
    if (reset && p_s === 1'b0) begin
      n_vec++;
      assert (Up === p_up) else begin
        n_err++;
        $error("FAIL up_stable: observed %0b expected %0b", Up, p_up);
      end
    end
    if (reset && S === 1'b0) begin
      n_vec++;
      assert (!((Up && floor == 4'(NF-1)) || (!Up && floor == 4'd0))) else begin
        n_err++;
        $error("FAIL limit: observed floor %0d Up %0b with S=0", floor, Up);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [NF-1:0] v);
    req = v;
    tick();
    req = '0;
  endtask

  task automatic wait_door(input logic val, input int lim, input string tag);
    int n;
    n = 0;
    while (door_open !== val && n < lim) begin
      tick();
      n++;
    end
    chk(tag, 32'(door_open), 32'(val));
  endtask

  task automatic count_door(input int n, output int cnt);
    cnt = int'(door_open);
    for (int i = 1; i < n; i++) begin
      tick();
      cnt += int'(door_open);
    end
  endtask

  int cnt;
  int mv;

  initial begin
    n_vec = 0;
    n_err = 0;
    req   = '0;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      req = NF'($urandom);
      tick();
      chk("rst_S", 32'(S), 32'd1);
      chk("rst_door", 32'(door_open), 32'd0);
      chk("rst_pend", 32'(pending), 32'd0);
      chk("rst_up", 32'(Up), 32'd1);
    end
    req   = '0;
    reset = 1'b1;
    run(6);
    chk("idle_S", 32'(S), 32'd1);
    chk("idle_mov", 32'(moving), 32'd0);
    chk("idle_floor", 32'(floor), 32'd0);

    pulse(NF'(1 << 3));
    chk("r3_pend", 32'(pending), 32'h008);
    chk("r3_idleS", 32'(S), 32'd1);
    tick();
    chk("r3_S0", 32'(S), 32'd0);
    chk("r3_up", 32'(Up), 32'd1);
    chk("r3_mov", 32'(moving), 32'd1);
    tick();
    chk("r3_f1", 32'(floor), 32'd1);
    tick();
    chk("r3_f2", 32'(floor), 32'd2);
    tick();
    chk("r3_f3", 32'(floor), 32'd3);
    chk("r3_stop", 32'(S), 32'd1);
    tick();
    count_door(12, cnt);
    chk("r3_doorlen", 32'(cnt), 32'd8);
    chk("r3_pend0", 32'(pending), 32'd0);
    chk("r3_floor", 32'(floor), 32'd3);
    chk("r3_idle", 32'(door_open), 32'd0);

    pulse(NF'(1 << 5));
    run(20);
    chk("to5_floor", 32'(floor), 32'd5);
    pulse(NF'(1 << 5));
    chk("h5_pend", 32'(pending), 32'h020);
    chk("h5_door0", 32'(door_open), 32'd0);
    tick();
    chk("h5_door1", 32'(door_open), 32'd1);
    mv = 0;
    cnt = int'(door_open);
    for (int i = 1; i < 12; i++) begin
      tick();
      cnt += int'(door_open);
      mv  += int'(moving);
    end
    chk("h5_doorlen", 32'(cnt), 32'd8);
    chk("h5_nomove", 32'(mv), 32'd0);
    chk("h5_floor", 32'(floor), 32'd5);

    pulse(NF'(1 << 2));
    run(25);
    chk("to2_floor", 32'(floor), 32'd2);
    chk("to2_up", 32'(Up), 32'd0);
    pulse(NF'(1 << 7));
    tick();
    chk("r7_up", 32'(Up), 32'd1);
    chk("r7_S", 32'(S), 32'd0);
    tick();
    chk("r7_f3", 32'(floor), 32'd3);
    pulse(NF'(1 << 4));
    chk("r4_f4", 32'(floor), 32'd4);
    chk("r4_stop", 32'(S), 32'd1);
    tick();
    count_door(12, cnt);
    chk("r4_doorlen", 32'(cnt), 32'd8);
    run(20);
    chk("r7_floor", 32'(floor), 32'd7);
    chk("r7_pend0", 32'(pending), 32'd0);

    pulse(NF'(1 << 3));
    run(25);
    chk("to3_floor", 32'(floor), 32'd3);
    pulse(NF'(1 << 4));
    run(20);
    chk("to4_floor", 32'(floor), 32'd4);
    chk("to4_up", 32'(Up), 32'd1);
    pulse(NF'((1 << 1) | (1 << 8)));
    chk("sc_pend", 32'(pending), 32'h102);
    wait_door(1'b1, 20, "sc_door8");
    chk("sc_f8", 32'(floor), 32'd8);
    tick();
    chk("sc_pend1", 32'(pending), 32'h002);
    wait_door(1'b0, 20, "sc_close8");
    wait_door(1'b1, 30, "sc_door1");
    chk("sc_f1", 32'(floor), 32'd1);
    chk("sc_dn", 32'(Up), 32'd0);
    run(12);
    chk("sc_pend0", 32'(pending), 32'd0);

    pulse(NF'(1 << 2));
    run(20);
    chk("ar_f2", 32'(floor), 32'd2);
    pulse(NF'(1 << 6));
    tick();
    chk("ar_mov", 32'(moving), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_S", 32'(S), 32'd1);
    chk("ar_up", 32'(Up), 32'd1);
    chk("ar_pend", 32'(pending), 32'd0);
    chk("ar_door", 32'(door_open), 32'd0);
    chk("ar_mov0", 32'(moving), 32'd0);
    #3 reset = 1'b1;
    run(10);
    chk("ar_idleS", 32'(S), 32'd1);
    chk("ar_floor", 32'(floor), 32'd0);
    chk("ar_pend2", 32'(pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/elevator_controller.md
# elevator_controller

Floor-scheduling controller that drives the 4-bit up/down floor counter. It latches per-floor call requests and compares them against the current floor count. It then generates the counter's direction (Up) and hold (S) controls so the car stops at every requested floor in sweep order, holding the door open for a fixed time at each stop. It sits upstream of the counter and consumes the counter's C3..C0 as its floor input.

## Interface
- NUM_FLOORS, 10, number of served floors (2..16); valid floors 0..NUM_FLOORS-1
- DOOR_CYCLES, 8, door-open duration in clock cycles (1..255)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_FLOORS  call buttons, bit i = floor i; any-width pulse, sampled each clk
- floor  in  4  current floor from counter ({C3,C2,C1,C0})
- Up  out  1  direction to counter: 1 = count up, 0 = count down
- S  out  1  counter hold: 1 = hold, 0 = step one floor at next clk
- door_open  out  1  door open indicator
- moving  out  1  high while state is MOVE and S=0
- pending  out  NUM_FLOORS  latched outstanding requests

## Operation
- Pending register: bit i sets at clk when req[i]=1. Bit i clears only while in DOOR with floor==i; set and clear on the same edge resolves to clear.
- dir register drives Up directly.
- ahead is the OR of pending bits strictly above floor (dir=1) or strictly below floor (dir=0).
- behind is the same set for the opposite direction.
- States: IDLE, MOVE, DOOR. Encoding is free.
- IDLE (S=1):
  - pending[floor] -> DOOR.
  - else ahead -> MOVE, dir unchanged.
  - else behind -> MOVE, dir toggles.
  - else stay.
- MOVE:
  - S=0 unless pending[floor]=1 or ahead=0. S is combinational from state, pending, floor.
  - pending[floor] -> DOOR; counter holds.
  - ahead=0 -> IDLE.
  - else stay; counter steps one floor.
- DOOR (S=1, door_open=1):
  - Timer loads DOOR_CYCLES-1 on entry and decrements each cycle.
  - A req for the current floor during DOOR reloads the timer and does not reopen.
  - At timer==0 -> IDLE.
- Limit safety: S=0 is never driven with Up=1 at floor NUM_FLOORS-1 or with Up=0 at floor 0. If that combination arises, force S=1 and go to IDLE.
- Invalid floor (floor >= NUM_FLOORS):
  - Force S=1 and state IDLE.
  - ahead/behind treat the car as above all floors, so dir=0 and the car returns down.
- Simultaneous requests above and below in IDLE: the current dir wins. This gives SCAN/elevator ordering.

## Timing
- Reset (asynchronous, immediate, independent of clk):
  - state=IDLE, dir=1 (Up=1), S=1, door_open=0, moving=0, pending=0, timer=0.
  - Reset asserted mid-MOVE or mid-DOOR abandons the operation; all pending requests are lost.
- Request latency: req high at edge k gives pending high after edge k.
  - IDLE reacts at edge k+1.
  - S drops combinationally in cycle k+1 if MOVE was entered at k+1.
- Step rate: one floor per clk while S=0.
- Stop behaviour: when floor reaches a pending floor, S=1 in that same cycle (combinational), so there is no overshoot.
- Door: door_open is high for exactly DOOR_CYCLES consecutive cycles with no intervening request, then IDLE for at least 1 cycle before the next MOVE.
- Outputs Up, door_open and pending are registered. S and moving are combinational from registers and floor.

## Test plan
The bench uses a behavioural counter: floor += Up?1:-1 at each clk where S=0; reset puts floor at 0.

- Reset held low, random req -> S=1, door_open=0, pending=0, Up=1 throughout. Release, no req -> stays IDLE indefinitely.
- floor=0, pulse req[3] one cycle:
  - pending=0x008 next cycle.
  - MOVE with Up=1, S=0; floor 1, 2, 3 on successive edges.
  - At floor 3, S=1 and DOOR; door_open high 8 cycles; pending[3] clears; then IDLE.
- Car idle at floor 5, req[5] -> DOOR on next edge, floor never changes, door_open 8 cycles.
- Car moving up from 2 toward pending 7, req[4] pulsed while floor=3 -> stops at 4 (DOOR 8 cycles), resumes up, stops at 7; pending ends 0.
- floor=4, dir=1, req[1] and req[8] same cycle -> serves 8 first, toggles Up to 0, serves 1. Up never changes while S=0.
- Reset asserted asynchronously mid-MOVE (floor=2 heading to 6) -> S=1, Up=1, pending=0, door_open=0 before the next clk edge. After release, stays IDLE.
